// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard/stall controller.
package hazard_pkg;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;
   localparam int MD_CNT_W       = 6;

endpackage

// File: rtl/md_busy_timer.sv
// Busy/done tracker for the multi-cycle multiply/divide unit: IDLE/BUSY FSM
// plus a down-counter of remaining busy cycles.
module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done,
   output logic cnt_nz
);

   localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

   md_state_t             state;
   logic [MD_CNT_W-1:0]   cnt;
   logic                  done_r;
   logic [MD_CNT_W-1:0]   load_val;

   assign load_val = is_div ? DIV_LOAD : MUL_LOAD;

   // Latencies are at least 2, so a fresh load never lands on done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MD_IDLE;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state <= MD_BUSY;
                  cnt   <= load_val;
               end
            end
            MD_BUSY: begin
               if (cnt != '0) begin
                  cnt    <= cnt - 1'b1;
                  done_r <= (cnt == MD_CNT_W'(1));
               end else if (start) begin
                  cnt    <= load_val;
                  done_r <= 1'b0;
               end else begin
                  state  <= MD_IDLE;
                  done_r <= 1'b0;
               end
            end
            default: begin
               state  <= MD_IDLE;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = (state == MD_BUSY);
   assign done   = done_r;
   assign cnt_nz = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use and mul/div stalls, taken-branch
// flushes, and a saturating stall-cycle counter.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  D_Rs,
   input  logic [4:0]  D_Rt,
   input  logic        D_UseRs,
   input  logic        D_UseRt,
   input  logic        D_IsMD,
   input  logic        D_IsDiv,
   input  logic        D_ReadHiLo,
   input  logic [4:0]  E_Rw,
   input  logic        E_MemRd,
   input  logic        E_RegWr,
   input  logic        Br_Taken,
   output logic        PC_Wr,
   output logic        D_Wr,
   output logic        D_Flush,
   output logic        E_Flush,
   output logic        MD_Busy,
   output logic        MD_Done,
   output logic [31:0] StallCnt
);

   logic        load_use;
   logic        md_hazard;
   logic        stall;
   logic        start;
   logic        md_cnt_nz;
   logic [31:0] stall_cnt_reg;

   assign load_use  = E_MemRd & E_RegWr & (E_Rw != 5'd0) &
                      ((D_UseRs & (D_Rs == E_Rw)) | (D_UseRt & (D_Rt == E_Rw)));
   assign md_hazard = MD_Busy & md_cnt_nz & (D_IsMD | D_ReadHiLo);
   assign stall     = (load_use | md_hazard) & ~Br_Taken;
   // A squashed mult/div must not start the unit.
   assign start     = D_IsMD & ~stall & ~Br_Taken;

   assign PC_Wr   = ~stall;
   assign D_Wr    = ~stall;
   assign D_Flush = Br_Taken;
   assign E_Flush = stall | Br_Taken;

   md_busy_timer #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_busy_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .is_div (D_IsDiv),
      .busy   (MD_Busy),
      .done   (MD_Done),
      .cnt_nz (md_cnt_nz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign StallCnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, hand sequences for
// multi-cycle cases, and randomized traffic against a cycle-number model.
module tb_hazard_stall_unit;

   localparam int MUL_L = 4;
   localparam int DIV_L = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  D_Rs, D_Rt, E_Rw;
   logic        D_UseRs, D_UseRt, D_IsMD, D_IsDiv, D_ReadHiLo;
   logic        E_MemRd, E_RegWr, Br_Taken;
   logic        PC_Wr, D_Wr, D_Flush, E_Flush, MD_Busy, MD_Done;
   logic [31:0] StallCnt;

   always #5 clk = ~clk;

   hazard_stall_unit #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
      .clk(clk), .rst_n(rst_n),
      .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
      .D_IsMD(D_IsMD), .D_IsDiv(D_IsDiv), .D_ReadHiLo(D_ReadHiLo),
      .E_Rw(E_Rw), .E_MemRd(E_MemRd), .E_RegWr(E_RegWr), .Br_Taken(Br_Taken),
      .PC_Wr(PC_Wr), .D_Wr(D_Wr), .D_Flush(D_Flush), .E_Flush(E_Flush),
      .MD_Busy(MD_Busy), .MD_Done(MD_Done), .StallCnt(StallCnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the unit is busy in cycles (issue, busy_end]; the
   // result is due in cycle busy_end.
   int          cyc = 0;
   int          busy_end = -1;
   logic [31:0] scnt_m = 32'd0;
   logic        do_preload = 1'b0;

   function automatic logic m_stall();
      logic lu, mh;
      lu = E_MemRd && E_RegWr && (E_Rw != 5'd0) &&
           ((D_UseRs && D_Rs == E_Rw) || (D_UseRt && D_Rt == E_Rw));
      mh = (cyc < busy_end) && (D_IsMD || D_ReadHiLo);
      return (lu || mh) && !Br_Taken;
   endfunction

   always @(posedge clk or negedge rst_n or posedge do_preload) begin
      if (!rst_n) begin
         busy_end <= cyc - 1;
         scnt_m   <= 32'd0;
      end else if (do_preload) begin
         scnt_m <= 32'hFFFF_FFFE;
      end else begin
         if (m_stall() && scnt_m != 32'hFFFF_FFFF) scnt_m <= scnt_m + 32'd1;
         if (D_IsMD && !m_stall() && !Br_Taken)
            busy_end <= cyc + (D_IsDiv ? DIV_L : MUL_L);
         cyc <= cyc + 1;
      end
   end

   task automatic check_all(input string tag);
      logic st;
      st = m_stall();
      chk({tag, ".PC_Wr"},    {31'd0, PC_Wr},    {31'd0, !st});
      chk({tag, ".D_Wr"},     {31'd0, D_Wr},     {31'd0, !st});
      chk({tag, ".D_Flush"},  {31'd0, D_Flush},  {31'd0, Br_Taken});
      chk({tag, ".E_Flush"},  {31'd0, E_Flush},  {31'd0, st || Br_Taken});
      chk({tag, ".MD_Busy"},  {31'd0, MD_Busy},  {31'd0, cyc <= busy_end});
      chk({tag, ".MD_Done"},  {31'd0, MD_Done},  {31'd0, cyc == busy_end});
      chk({tag, ".StallCnt"}, StallCnt, scnt_m);
   endtask

   task automatic idle();
      D_Rs = 0; D_Rt = 0; E_Rw = 0; D_UseRs = 0; D_UseRt = 0; D_IsMD = 0;
      D_IsDiv = 0; D_ReadHiLo = 0; E_MemRd = 0; E_RegWr = 0; Br_Taken = 0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_load_use();
      E_MemRd = 1; E_RegWr = 1; E_Rw = 5'd8; D_Rs = 5'd8; D_UseRs = 1;
   endtask

   typedef struct {
      string      name;
      logic [4:0] rs, rt, rw;
      logic       use_rs, use_rt, is_md, mem_rd, reg_wr, br;
      logic [3:0] exp;   // {PC_Wr, D_Wr, D_Flush, E_Flush}
   } vec_t;

   vec_t tab[9];

   initial begin
      int stalls, busy_n, issued, issued2;
      logic [31:0] saved;

      tab[0] = '{"lu_rs",     5'd8, 5'd0, 5'd8, 1, 0, 0, 1, 1, 0, 4'b0001};
      tab[1] = '{"rw_zero",   5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 0, 4'b1100};
      tab[2] = '{"no_use_rs", 5'd8, 5'd0, 5'd8, 0, 0, 0, 1, 1, 0, 4'b1100};
      tab[3] = '{"lu_rt",     5'd1, 5'd9, 5'd9, 1, 1, 0, 1, 1, 0, 4'b0001};
      tab[4] = '{"no_regwr",  5'd8, 5'd0, 5'd8, 1, 0, 0, 1, 0, 0, 4'b1100};
      tab[5] = '{"no_load",   5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 1, 0, 4'b1100};
      tab[6] = '{"br_prio",   5'd8, 5'd0, 5'd8, 1, 0, 1, 1, 1, 1, 4'b1111};
      tab[7] = '{"br_only",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 4'b1111};
      tab[8] = '{"quiet",     5'd3, 5'd4, 5'd5, 1, 1, 0, 1, 1, 0, 4'b1100};

      // Reset state
      idle();
      #1;
      chk("rst.PC_Wr", {31'd0, PC_Wr}, 32'd1);
      chk("rst.D_Wr", {31'd0, D_Wr}, 32'd1);
      chk("rst.flush", {30'd0, D_Flush, E_Flush}, 32'd0);
      chk("rst.MD", {30'd0, MD_Busy, MD_Done}, 32'd0);
      chk("rst.StallCnt", StallCnt, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Load-use: one stall cycle, counter 0 -> 1
      set_load_use();
      #1;
      chk("lu.PC_Wr", {31'd0, PC_Wr}, 32'd0);
      chk("lu.D_Wr", {31'd0, D_Wr}, 32'd0);
      chk("lu.E_Flush", {31'd0, E_Flush}, 32'd1);
      chk("lu.cnt0", StallCnt, 32'd0);
      tick();
      idle();
      #1;
      chk("lu.cnt1", StallCnt, 32'd1);
      chk("lu.released", {31'd0, PC_Wr}, 32'd1);
      $display("seq load_use: StallCnt=%0d", StallCnt);
      tick();

      // Vector table
      for (int i = 0; i < 9; i++) begin
         D_Rs = tab[i].rs; D_Rt = tab[i].rt; E_Rw = tab[i].rw;
         D_UseRs = tab[i].use_rs; D_UseRt = tab[i].use_rt; D_IsMD = tab[i].is_md;
         D_IsDiv = 0; D_ReadHiLo = 0;
         E_MemRd = tab[i].mem_rd; E_RegWr = tab[i].reg_wr; Br_Taken = tab[i].br;
         #1;
         chk({"tab.", tab[i].name}, {28'd0, PC_Wr, D_Wr, D_Flush, E_Flush}, {28'd0, tab[i].exp});
         check_all({"tab.", tab[i].name});
         $display("vec %s: outs=%b", tab[i].name, {PC_Wr, D_Wr, D_Flush, E_Flush});
         tick();
      end
      idle();
      #1;
      chk("tab.no_md_start", {31'd0, MD_Busy}, 32'd0);
      tick();

      // Multiply then dependent mfhi
      do_reset();
      D_IsMD = 1;
      #1 check_all("mul.issue");
      tick();
      idle();
      D_ReadHiLo = 1;
      stalls = 0; busy_n = 0; issued = 0;
      for (int i = 0; i < 10 && issued == 0; i++) begin
         #1 check_all("mul.wait");
         if (MD_Busy) busy_n++;
         if (!PC_Wr) stalls++;
         else begin
            chk("mul.done_at_issue", {31'd0, MD_Done}, 32'd1);
            issued = 1;
         end
         tick();
      end
      idle();
      #1;
      chk("mul.issued", issued, 32'd1);
      chk("mul.stalls", stalls, 32'd3);
      chk("mul.busy_cycles", busy_n, 32'd4);
      chk("mul.StallCnt", StallCnt, 32'd3);
      chk("mul.idle_after", {31'd0, MD_Busy}, 32'd0);
      $display("seq mul_mfhi: stalls=%0d busy=%0d", stalls, busy_n);
      tick();

      // Divide back-to-back
      D_IsMD = 1; D_IsDiv = 1;
      #1 check_all("div.issue1");
      tick();
      busy_n = 0; issued2 = 0;
      for (int i = 0; i < 200; i++) begin
         if (issued2 == 0) begin D_IsMD = 1; D_IsDiv = 1; end
         else idle();
         #1 check_all("div.run");
         if (MD_Busy) busy_n++;
         else break;
         if (issued2 == 0 && PC_Wr) begin
            chk("div.issue2_at_done", {31'd0, MD_Done}, 32'd1);
            issued2 = 1;
         end
         tick();
      end
      chk("div.issued2", issued2, 32'd1);
      chk("div.busy_cycles", busy_n, 32'd64);
      $display("seq div_div: busy=%0d", busy_n);
      idle();
      tick();

      // Branch priority over load-use and mult start
      saved = scnt_m;
      set_load_use();
      D_IsMD = 1; Br_Taken = 1;
      #1;
      chk("br.D_Flush", {31'd0, D_Flush}, 32'd1);
      chk("br.E_Flush", {31'd0, E_Flush}, 32'd1);
      chk("br.PC_Wr", {31'd0, PC_Wr}, 32'd1);
      check_all("br");
      tick();
      idle();
      #1;
      chk("br.no_start", {31'd0, MD_Busy}, 32'd0);
      chk("br.StallCnt", StallCnt, saved);
      $display("seq branch: flush=%b%b", D_Flush, E_Flush);
      tick();

      // Reset in the middle of a divide
      D_IsMD = 1; D_IsDiv = 1;
      #1 check_all("rdiv.issue");
      tick();
      idle();
      for (int i = 0; i < 9; i++) tick();
      #1 check_all("rdiv.busy10");
      chk("rdiv.pre_cnt_nonzero", {31'd0, StallCnt != 32'd0}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rdiv.MD_Busy", {31'd0, MD_Busy}, 32'd0);
      chk("rdiv.MD_Done", {31'd0, MD_Done}, 32'd0);
      chk("rdiv.StallCnt", StallCnt, 32'd0);
      chk("rdiv.PC_Wr", {31'd0, PC_Wr}, 32'd1);
      $display("seq reset_mid_div: busy=%b cnt=%0d", MD_Busy, StallCnt);
      tick();
      rst_n = 1'b1;
      tick();

      // Saturation
      force dut.stall_cnt_reg = 32'hFFFF_FFFE;
      do_preload = 1'b1;
      #1;
      release dut.stall_cnt_reg;
      do_preload = 1'b0;
      set_load_use();
      for (int i = 0; i < 3; i++) begin
         #1 check_all("sat");
         tick();
      end
      idle();
      #1;
      chk("sat.hold", StallCnt, 32'hFFFF_FFFF);
      $display("seq saturate: StallCnt=%h", StallCnt);
      tick();

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         D_Rs = 5'($urandom_range(0, 3));
         D_Rt = 5'($urandom_range(0, 3));
         E_Rw = 5'($urandom_range(0, 3));
         D_UseRs = 1'($urandom);
         D_UseRt = 1'($urandom);
         D_IsMD = ($urandom_range(0, 5) == 0);
         D_IsDiv = ($urandom_range(0, 3) == 0);
         D_ReadHiLo = ($urandom_range(0, 4) == 0);
         E_MemRd = 1'($urandom);
         E_RegWr = ($urandom_range(0, 3) != 0);
         Br_Taken = ($urandom_range(0, 7) == 0);
         #1 check_all("rnd");
         tick();
      end
      idle();
      $display("random: %0d cycles, StallCnt=%0d", 3000, StallCnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard controller for the 5-stage MIPS pipeline, the stall/flush side of operand forwarding: it handles the cases forwarding cannot cover. It stalls on load-use dependences and on accesses to the multi-cycle multiply/divide unit while that unit is busy. It flushes wrong-path instructions on a taken branch and keeps a saturating stall-cycle performance counter.

## Interface
- MUL_CYCLES, default 4: multiply latency in cycles, 2..64.
- DIV_CYCLES, default 32: divide latency in cycles, 2..64.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- D_Rs, D_Rt  in  5 each  source registers of the instruction in decode.
- D_UseRs, D_UseRt  in  1 each  the decode instruction actually reads that source.
- D_IsMD  in  1  decode instruction is mult/multu/div/divu.
- D_IsDiv  in  1  qualifies D_IsMD: divide, not multiply.
- D_ReadHiLo  in  1  decode instruction is mfhi/mflo/mthi/mtlo.
- E_Rw  in  5  destination register in execute.
- E_MemRd  in  1  execute instruction is a load.
- E_RegWr  in  1  execute instruction writes a register.
- Br_Taken  in  1  branch/jump resolved taken in execute.
- PC_Wr  out  1  PC write enable.
- D_Wr  out  1  IF/ID register write enable.
- D_Flush  out  1  clear IF/ID to a nop.
- E_Flush  out  1  insert a bubble into ID/EX.
- MD_Busy  out  1  multiply/divide unit is in the BUSY state.
- MD_Done  out  1  last busy cycle; HI/LO are valid at the next edge.
- StallCnt  out  32  count of stall cycles, saturating.

## Operation
- load_use = E_MemRd & E_RegWr & (E_Rw≠0) & ((D_UseRs & D_Rs==E_Rw) | (D_UseRt & D_Rt==E_Rw)).
- md_hazard = MD_Busy & (cnt≠0) & (D_IsMD | D_ReadHiLo).
- stall = (load_use | md_hazard) & ~Br_Taken.
- Normal cycle: PC_Wr=1, D_Wr=1, D_Flush=0, E_Flush=0.
- Stall cycle: PC_Wr=0, D_Wr=0, E_Flush=1, D_Flush=0.
- Br_Taken has priority over stall: PC_Wr=1, D_Wr=1, D_Flush=1, E_Flush=1.
- MD FSM has two states, IDLE and BUSY, and a 6-bit down-counter cnt.
  - start = D_IsMD & ~stall & ~Br_Taken.
  - IDLE, start: go to BUSY; cnt ← (D_IsDiv ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY, cnt≠0: decrement cnt; start cannot occur because md_hazard stalls it.
  - BUSY, cnt==0: MD_Done=1. If start, reload cnt and stay in BUSY (back-to-back ops). Otherwise go to IDLE.
- MD_Busy = (state==BUSY). MD_Done = BUSY & cnt==0. Both come straight from registers.
- A squashed MD instruction (Br_Taken in the same cycle) never starts the FSM.
- StallCnt increments on every cycle with stall=1 and holds at 0xFFFF_FFFF.

## Timing
- Outputs PC_Wr, D_Wr, D_Flush and E_Flush are combinational; there are no registered paths from inputs to these outputs.
- FSM, cnt and StallCnt update on the rising edge of clk.
- Reset (any time, including mid-operation) forces state=IDLE, cnt=0 and StallCnt=0.
  - This gives MD_Busy=0 and MD_Done=0.
  - With all inputs 0: PC_Wr=1, D_Wr=1, D_Flush=0, E_Flush=0.
  - An in-flight mult/div is abandoned.
- A load-use dependence costs exactly 1 stall cycle. The load then sits in M, and forwarding from W covers the operand.
- Multiply issued at edge T:
  - BUSY for the cycles after T, T+1, T+2 and T+3; MD_Done is high in the last of these.
  - A dependent mfhi in decode stalls 3 cycles and issues in the MD_Done cycle.
- A load-use stall and md_hazard together produce a single stall cycle per cycle, not a double count.
- E_Rw==0 never causes a stall.

## Structure
- Shared package `hazard_pkg`:
  - md_state_t enum {MD_IDLE, MD_BUSY};
  - constants MUL_CYCLES_DEF=4 and DIV_CYCLES_DEF=32;
  - MD_CNT_W=6.
- One sub-module, `md_busy_timer`, holds the FSM and counter. Inputs: start, is_div. Outputs: busy, done, cnt_nz.
- The top level holds the hazard equations, the flush/stall muxing and StallCnt.

## Test plan
- Load-use, single cycle:
  - Stimulus: E_MemRd=1, E_RegWr=1, E_Rw=8, D_Rs=8, D_UseRs=1.
  - Response: PC_Wr=0, D_Wr=0, E_Flush=1 for one cycle; StallCnt goes 0→1.
  - Repeat with E_Rw=0: no stall.
  - Repeat with D_UseRs=0: no stall.
- Multiply then dependent mfhi:
  - Stimulus: D_IsMD=1, D_IsDiv=0, then D_ReadHiLo=1.
  - Response: MD_Busy high for 4 cycles; 3 stall cycles; MD_Done on the 4th; StallCnt=3.
- Divide back-to-back:
  - Stimulus: div, then div.
  - Response: the second div issues in the MD_Done cycle; FSM stays BUSY; total MD_Busy = 64 consecutive cycles.
- Branch priority:
  - Stimulus: Br_Taken=1 together with load_use and D_IsMD.
  - Response: D_Flush=1, E_Flush=1, PC_Wr=1; no FSM start; StallCnt unchanged.
- Reset mid-divide:
  - Stimulus: assert rst_n=0 at busy cycle 10.
  - Response: MD_Busy=0 and StallCnt=0 immediately, without waiting for a clock edge.
- Saturation:
  - Stimulus: force StallCnt to 0xFFFF_FFFE, then apply 3 stall cycles.
  - Response: StallCnt holds at 0xFFFF_FFFF.
